nn_stream_framer: RTL and testbench

- Stream source for the nn pixel pipeline.
- Takes a raw beat stream with only a valid strobe and a frame-start qualifier.
- Emits the framed stream (data, data_valid, sop, eop, sof, eof) consumed by the conv and deconv layer chains.
- Sits between the camera/DMA input and the first network layer; it is the transmitter side of the framing protocol those layers receive.

---
 rtl/nn_stream_pkg.sv | 20 ++
 rtl/nn_wrap_cnt.sv | 38 +++
 rtl/nn_stream_framer.sv | 140 ++++++++++++++
 tb/tb_nn_stream_framer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_stream_pkg.sv
// Shared types for the nn stream pipeline: beat flags, framer states and a width helper.
package nn_stream_pkg;

  typedef struct packed {
    logic sop;
    logic eof;
    logic sof;
    logic eop;
  } stream_flags_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } framer_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_wrap_cnt.sv
// Modulo-MAX counter. clr restarts from zero in the same cycle, so clr together with inc
// loads the successor of zero.
module nn_wrap_cnt
  import nn_stream_pkg::*;
#(
  parameter int unsigned MAX   = 2,
  parameter int unsigned WIDTH = clog2_min1(MAX)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] count_nxt;

  always_comb begin
    base      = clr ? '0 : count;
    count_nxt = base;
    if (inc) begin
      count_nxt = (base == WIDTH'(MAX - 1)) ? '0 : base + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign at_max = (count == WIDTH'(MAX - 1));

endmodule

// File: rtl/nn_stream_framer.sv
// Frames a raw valid/frame-start beat stream into sop/eop/sof/eof beats, one cycle latency.
// Optional statistics (err_o, frame_cnt_o) are built when NN_FRAMER_STAT_EN is defined.
module nn_stream_framer
  import nn_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STRING_LEN  = 7,
  parameter int unsigned STRING_NUM  = 7,
  parameter int unsigned CHANNEL_NUM = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic                  frame_start_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o
`ifdef NN_FRAMER_STAT_EN
  ,
  output logic                  err_o,
  output logic [15:0]           frame_cnt_o
`endif
);

  localparam int unsigned CH_W  = clog2_min1(CHANNEL_NUM);
  localparam int unsigned COL_W = clog2_min1(STRING_LEN);
  localparam int unsigned ROW_W = clog2_min1(STRING_NUM);

  framer_state_t state, state_nxt;
  stream_flags_t flags, flags_q;

  logic             start, accept;
  logic             ch_first, col_first, row_first;
  logic             ch_last, col_last, row_last;
  logic             ch_at_max, col_at_max, row_at_max;
  logic             col_inc, row_inc;
  logic [CH_W-1:0]  ch_cnt;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;

  // A frame start forces the beat to position (0,0,0) regardless of the counters,
  // so first/last are evaluated against that position rather than the stored count.
  always_comb begin
    start     = data_valid_i && frame_start_i;
    accept    = data_valid_i && ((state == ACTIVE) || frame_start_i);
    ch_first  = start || (ch_cnt == '0);
    col_first = start || (col_cnt == '0);
    row_first = start || (row_cnt == '0);
    ch_last   = start ? (CHANNEL_NUM == 1) : ch_at_max;
    col_last  = start ? (STRING_LEN == 1) : col_at_max;
    row_last  = start ? (STRING_NUM == 1) : row_at_max;
    col_inc   = accept && ch_last;
    row_inc   = accept && ch_last && col_last;

    flags     = '0;
    flags.sop = ch_first && col_first;
    flags.eop = ch_last && col_last;
    flags.sof = flags.sop && row_first;
    flags.eof = flags.eop && row_last;

    state_nxt = state;
    if (accept) begin
      state_nxt = flags.eof ? IDLE : ACTIVE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The eof beat wraps every counter back to zero, so no explicit clear is needed there.
  nn_wrap_cnt #(.MAX(CHANNEL_NUM), .WIDTH(CH_W)) u_ch_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (accept),
    .clr    (start),
    .count  (ch_cnt),
    .at_max (ch_at_max)
  );

  nn_wrap_cnt #(.MAX(STRING_LEN), .WIDTH(COL_W)) u_col_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (col_inc),
    .clr    (start),
    .count  (col_cnt),
    .at_max (col_at_max)
  );

  nn_wrap_cnt #(.MAX(STRING_NUM), .WIDTH(ROW_W)) u_row_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (row_inc),
    .clr    (start),
    .count  (row_cnt),
    .at_max (row_at_max)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
      flags_q      <= '0;
    end else begin
      data_valid_o <= accept;
      flags_q      <= accept ? flags : '0;
      if (accept) begin
        data_o <= data_i;
      end
    end
  end

  assign sop_o = flags_q.sop;
  assign eop_o = flags_q.eop;
  assign sof_o = flags_q.sof;
  assign eof_o = flags_q.eof;

`ifdef NN_FRAMER_STAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_o       <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      err_o <= start && (state == ACTIVE);
      if (eof_o) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nn_stream_framer.sv
// Directed bench for nn_stream_framer: a 4x3x2 instance plus a degenerate 1x1x1 instance.
module tb_nn_stream_framer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_i;
  logic       data_valid_i, frame_start_i;
  logic [7:0] data_o;
  logic       data_valid_o, sop_o, eop_o, sof_o, eof_o;
  logic       err_o;
  logic [15:0] frame_cnt_o;

  logic [7:0] d1_data_i;
  logic       d1_valid_i, d1_start_i;
  logic [7:0] d1_data_o;
  logic       d1_valid_o, d1_sop, d1_eop, d1_sof, d1_eof;
  logic       d1_err;
  logic [15:0] d1_frame_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  last_data;

  always #5 clk = ~clk;

  nn_stream_framer #(
    .DATA_WIDTH (8),
    .STRING_LEN (4),
    .STRING_NUM (3),
    .CHANNEL_NUM(2)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .frame_start_i(frame_start_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .sop_o        (sop_o),
    .eop_o        (eop_o),
    .sof_o        (sof_o),
    .eof_o        (eof_o)
`ifdef NN_FRAMER_STAT_EN
    ,
    .err_o        (err_o),
    .frame_cnt_o  (frame_cnt_o)
`endif
  );

  nn_stream_framer #(
    .DATA_WIDTH (8),
    .STRING_LEN (1),
    .STRING_NUM (1),
    .CHANNEL_NUM(1)
  ) u_dut1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_i       (d1_data_i),
    .data_valid_i (d1_valid_i),
    .frame_start_i(d1_start_i),
    .data_o       (d1_data_o),
    .data_valid_o (d1_valid_o),
    .sop_o        (d1_sop),
    .eop_o        (d1_eop),
    .sof_o        (d1_sof),
    .eof_o        (d1_eof)
`ifdef NN_FRAMER_STAT_EN
    ,
    .err_o        (d1_err),
    .frame_cnt_o  (d1_frame_cnt)
`endif
  );

`ifndef NN_FRAMER_STAT_EN
  assign err_o        = 1'b0;
  assign frame_cnt_o  = '0;
  assign d1_err       = 1'b0;
  assign d1_frame_cnt = '0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of input, then check the registered beat one cycle later.
  task automatic beat(input logic v, input logic fs, input logic [7:0] d, input logic ev,
                      input logic esop, input logic eeop, input logic esof, input logic eeof,
                      input logic eerr);
    data_valid_i  = v;
    frame_start_i = fs;
    data_i        = d;
    @(negedge clk);
    if (ev) last_data = d;
    check_eq("data_valid", {31'd0, data_valid_o}, {31'd0, ev});
    check_eq("data", {24'd0, data_o}, {24'd0, last_data});
    check_eq("sop", {31'd0, sop_o}, {31'd0, esop});
    check_eq("eop", {31'd0, eop_o}, {31'd0, eeop});
    check_eq("sof", {31'd0, sof_o}, {31'd0, esof});
    check_eq("eof", {31'd0, eof_o}, {31'd0, eeof});
`ifdef NN_FRAMER_STAT_EN
    check_eq("err", {31'd0, err_o}, {31'd0, eerr});
`endif
    data_valid_i  = 1'b0;
    frame_start_i = 1'b0;
  endtask

  task automatic frame_beat(input int idx, input logic fs, input logic [7:0] d);
    beat(1'b1, fs, d, 1'b1, (idx % 8) == 0, (idx % 8) == 7, idx == 0, idx == 23, 1'b0);
  endtask

  task automatic idle_beat(input logic [7:0] d);
    beat(1'b0, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic dropped_beat(input logic fs, input logic [7:0] d);
    beat(1'b1, fs, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic full_frame(input logic gaps);
    for (int i = 0; i < 24; i++) begin
      frame_beat(i, i == 0, 8'(i));
      if (gaps) idle_beat(8'hA5);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp);
`ifdef NN_FRAMER_STAT_EN
    check_eq(tag, {16'd0, frame_cnt_o}, {16'd0, exp});
`endif
  endtask

  task automatic beat1(input logic v, input logic fs, input logic [7:0] d, input logic ev);
    d1_valid_i = v;
    d1_start_i = fs;
    d1_data_i  = d;
    @(negedge clk);
    check_eq("d1_valid", {31'd0, d1_valid_o}, {31'd0, ev});
    check_eq("d1_flags", {28'd0, d1_sop, d1_eop, d1_sof, d1_eof}, {28'd0, {4{ev}}});
    if (ev) check_eq("d1_data", {24'd0, d1_data_o}, {24'd0, d});
    d1_valid_i = 1'b0;
    d1_start_i = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    data_i        = '0;
    data_valid_i  = 1'b0;
    frame_start_i = 1'b0;
    d1_data_i     = '0;
    d1_valid_i    = 1'b0;
    d1_start_i    = 1'b0;
    last_data     = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_outputs", {24'd0, data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, 2'b00}, 32'd0);
    check_eq("rst_d1_outputs", {24'd0, d1_data_o, d1_valid_o, d1_sop, d1_eop, d1_sof, d1_eof, d1_err, 2'b00}, 32'd0);
    check_cnt("rst_frame_cnt", 16'd0);
    reset_n = 1'b1;

    // Continuous frame
    full_frame(1'b0);
    idle_beat(8'h00);
    check_cnt("frame_cnt_s1", 16'd1);

    // Every other cycle valid
    full_frame(1'b1);
    check_cnt("frame_cnt_s2", 16'd2);

    // Beats before any frame start are dropped
    for (int i = 0; i < 5; i++) dropped_beat(1'b0, 8'(50 + i));
    full_frame(1'b0);
    idle_beat(8'h00);
    check_cnt("frame_cnt_s3", 16'd3);

    // Truncation on beat 10
    for (int i = 0; i < 10; i++) frame_beat(i, i == 0, 8'(i));
    beat(1'b1, 1'b1, 8'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 24; i++) frame_beat(i, 1'b0, 8'(10 + i));
    idle_beat(8'h00);
    check_cnt("frame_cnt_trunc", 16'd4);

    // Truncation on the beat that would have been eof
    for (int i = 0; i < 23; i++) frame_beat(i, i == 0, 8'(100 + i));
    beat(1'b1, 1'b1, 8'd200, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 24; i++) frame_beat(i, 1'b0, 8'(200 + i));
    idle_beat(8'h00);
    check_cnt("frame_cnt_trunc_eof", 16'd5);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 12; i++) frame_beat(i, i == 0, 8'(i));
    data_valid_i  = 1'b1;
    frame_start_i = 1'b0;
    data_i        = 8'd12;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_outputs", {24'd0, data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, err_o, 2'b00}, 32'd0);
    check_cnt("async_rst_frame_cnt", 16'd0);
    last_data = '0;
    @(negedge clk);
    data_valid_i = 1'b0;
    reset_n      = 1'b1;
    for (int i = 0; i < 3; i++) dropped_beat(1'b0, 8'(60 + i));
    full_frame(1'b0);
    idle_beat(8'h00);
    check_cnt("frame_cnt_after_rst", 16'd1);

    // Degenerate 1x1x1 framer
    beat1(1'b1, 1'b1, 8'd1, 1'b1);
    beat1(1'b1, 1'b0, 8'd2, 1'b0);
    beat1(1'b1, 1'b1, 8'd3, 1'b1);
    beat1(1'b0, 1'b0, 8'd0, 1'b0);
    beat1(1'b1, 1'b1, 8'd5, 1'b1);
    beat1(1'b0, 1'b0, 8'd0, 1'b0);
`ifdef NN_FRAMER_STAT_EN
    check_eq("d1_frame_cnt", {16'd0, d1_frame_cnt}, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
